recall_judge: RTL and testbench
===============================

Name: recall_judge

Overview:
- Round controller directly downstream of the 8-bit board generator.
- Latches one generated board, shows it to the player for a fixed time, then hides it and accepts tile guesses.
- Each guess is scored against the latched board; the block declares win or lose.
- Drives the 8-tile display mask and the score/status outputs consumed by the LED/HEX front end.

Parameters:
- SHOW_CYCLES, 50000000: clock cycles the board stays visible (must be >= 1).
- TIMER_W, 26: show-timer width; must satisfy 2^TIMER_W > SHOW_CYCLES.
- MAX_MISSES, 3: wrong guesses that end the round (1..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- board  in  8  board from the generator; bit i set = tile i is lit.
- board_valid  in  1  1-cycle strobe: board is stable, start a round.
- guess_valid  in  1  1-cycle strobe: player pressed a tile.
- guess_idx  in  3  tile index of the guess.
- display  out  8  tile lamps.
- found  out  8  correctly recalled tiles.
- misses  out  3  wrong guesses so far.
- hit  out  1  1-cycle pulse: new correct tile.
- miss  out  1  1-cycle pulse: wrong tile.
- busy  out  1  round in progress (SHOW or RECALL).
- win  out  1  level, held in WIN.
- lose  out  1  level, held in LOSE.

Behaviour:
- All outputs are registered.
- Reset asserted, at any time including mid-round, forces state IDLE.
  - board_q, found, misses, timer, display, hit, miss, win, lose, busy all clear to 0.
  - Takes effect immediately; no clock edge needed.
- States: IDLE, SHOW, RECALL, WIN, LOSE.
- IDLE / WIN / LOSE:
  - On board_valid: latch board_q <= board, clear found, misses and timer, go to SHOW, clear win/lose.
  - Otherwise hold.
  - guess_valid is ignored.
- SHOW:
  - display = board_q and busy = 1.
  - timer increments every cycle. When timer == SHOW_CYCLES-1, the next edge leaves SHOW, so the state is SHOW for exactly SHOW_CYCLES cycles.
  - Exit to RECALL if board_q != 0; exit straight to WIN if board_q == 0.
  - guess_valid and board_valid are ignored.
- RECALL:
  - display = found and busy = 1.
  - board_valid is ignored.
  - On guess_valid with idx = guess_idx:
    - board_q[idx]=1 and found[idx]=0: set found[idx]; hit=1 next cycle.
    - board_q[idx]=1 and found[idx]=1: duplicate; no change, no pulse, no penalty.
    - board_q[idx]=0: misses+1; miss=1 next cycle.
  - Win: if the next value of found equals board_q, enter WIN on the same edge that registers the final hit. The hit pulse is still emitted.
  - Lose: if the next value of misses equals MAX_MISSES, enter LOSE on the same edge. The miss pulse is still emitted.
- WIN: display = board_q, win = 1. LOSE: display = board_q (reveal), lose = 1.
- misses never exceeds MAX_MISSES and never wraps.
- found is always a subset of board_q.
- hit and miss are never high together; each lasts exactly one cycle.
- Latency: guess strobe on edge N means found, misses, hit/miss and the state change are visible after edge N. No further pipeline stages.
- The board input is sampled only on the board_valid edge; later changes to it have no effect on the round.

Test Plan:
- SHOW_CYCLES=4, MAX_MISSES=3 for all scenarios.
- Reset, then board_valid with board=8'b1000_0101 -> display=8'h85 and busy=1 for exactly 4 cycles, then display=8'h00 in RECALL, win=lose=0.
- RECALL on board 8'h85, guesses 0, 2, 7 on separated cycles -> found goes 01 -> 05 -> 85; three hit pulses. WIN is entered on the edge of guess 7, then win=1, display=8'h85, busy=0.
- Board 8'h85, guesses 1, 0, 0, 3, 4 -> miss, hit, duplicate (no pulse, found=01), miss, miss. misses=3 and LOSE on the edge of guess 4; display=8'h85, lose=1; later guesses are ignored.
- Board 8'h00 -> 4 SHOW cycles, then WIN directly with no RECALL cycle. Guesses and board_valid during SHOW -> no change to found, misses or board_q.
- Reset asserted asynchronously mid-RECALL, after found=8'h01, misses=1 -> all outputs 0 before the next clk edge. State IDLE after release; a new board_valid starts a clean round.
- From LOSE, board_valid with board=8'h3C -> lose clears, board_q=8'h3C, found=0, misses=0, SHOW restarts for 4 cycles.

Source files
------------

// File: rtl/recall_judge.sv
// rtl/recall_judge.sv - memory-game round controller: show a latched board, score tile guesses, declare win/lose
module recall_judge #(
    parameter int SHOW_CYCLES = 50000000,
    parameter int TIMER_W     = 26,
    parameter int MAX_MISSES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] board,
    input  logic       board_valid,
    input  logic       guess_valid,
    input  logic [2:0] guess_idx,
    output logic [7:0] display,
    output logic [7:0] found,
    output logic [2:0] misses,
    output logic       hit,
    output logic       miss,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW   = 3'd1,
        ST_RECALL = 3'd2,
        ST_WIN    = 3'd3,
        ST_LOSE   = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [2:0]         MISS_MAX  = 3'(MAX_MISSES);

    state_t             state_q, state_d;
    logic [7:0]         board_q, board_d;
    logic [7:0]         found_q, found_d;
    logic [2:0]         misses_q, misses_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         display_q, display_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               busy_q, busy_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic [7:0]         guess_bit;

    assign guess_bit = 8'(1) << guess_idx;

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        found_d  = found_q;
        misses_d = misses_q;
        timer_d  = timer_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (board_valid) begin
                    board_d  = board;
                    found_d  = 8'h00;
                    misses_d = 3'd0;
                    timer_d  = '0;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == SHOW_LAST) begin
                    timer_d = '0;
                    state_d = (board_q != 8'h00) ? ST_RECALL : ST_WIN;
                end
            end
            ST_RECALL: begin
                if (guess_valid) begin
                    if ((board_q & guess_bit) != 8'h00) begin
                        // Repeat presses of an already found tile are free.
                        if ((found_q & guess_bit) == 8'h00) begin
                            found_d = found_q | guess_bit;
                            hit_d   = 1'b1;
                            if (found_d == board_q) begin
                                state_d = ST_WIN;
                            end
                        end
                    end else begin
                        misses_d = misses_q + 3'd1;
                        miss_d   = 1'b1;
                        if (misses_d == MISS_MAX) begin
                            state_d = ST_LOSE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs follow the state being entered so they are registered alongside it.
    always_comb begin
        display_d = 8'h00;
        busy_d    = 1'b0;
        win_d     = 1'b0;
        lose_d    = 1'b0;
        case (state_d)
            ST_SHOW: begin
                display_d = board_d;
                busy_d    = 1'b1;
            end
            ST_RECALL: begin
                display_d = found_d;
                busy_d    = 1'b1;
            end
            ST_WIN: begin
                display_d = board_d;
                win_d     = 1'b1;
            end
            ST_LOSE: begin
                display_d = board_d;
                lose_d    = 1'b1;
            end
            default: display_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            board_q   <= 8'h00;
            found_q   <= 8'h00;
            misses_q  <= 3'd0;
            timer_q   <= '0;
            display_q <= 8'h00;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            found_q   <= found_d;
            misses_q  <= misses_d;
            timer_q   <= timer_d;
            display_q <= display_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            busy_q    <= busy_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign display = display_q;
    assign found   = found_q;
    assign misses  = misses_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign busy    = busy_q;
    assign win     = win_q;
    assign lose    = lose_q;

endmodule

// File: tb/tb_recall_judge.sv
// tb/tb_recall_judge.sv - randomized bench for recall_judge against a round-level reference model
module tb_recall_judge;

    localparam int SHOW = 4;
    localparam int MAXM = 3;

    logic       clk;
    logic       reset;
    logic [7:0] board;
    logic       board_valid;
    logic       guess_valid;
    logic [2:0] guess_idx;
    logic [7:0] display;
    logic [7:0] found;
    logic [2:0] misses;
    logic       hit;
    logic       miss;
    logic       busy;
    logic       win;
    logic       lose;

    recall_judge #(
        .SHOW_CYCLES(SHOW),
        .TIMER_W(4),
        .MAX_MISSES(MAXM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .board(board),
        .board_valid(board_valid),
        .guess_valid(guess_valid),
        .guess_idx(guess_idx),
        .display(display),
        .found(found),
        .misses(misses),
        .hit(hit),
        .miss(miss),
        .busy(busy),
        .win(win),
        .lose(lose)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference round: phase 0 idle, 1 showing, 2 recalling, 3 won, 4 lost.
    int         m_phase;
    int         m_show_left;
    logic [7:0] m_board;
    logic [7:0] m_found;
    int         m_misses;
    logic       m_hit;
    logic       m_miss;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (disp,found,miss#,hit,miss,busy,win,lose)", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {8'h00, display, found, misses, hit, miss, busy, win, lose};
    endfunction

    function automatic logic [31:0] expected();
        logic [7:0] d;
        d = 8'h00;
        if (m_phase == 1 || m_phase == 3 || m_phase == 4) d = m_board;
        if (m_phase == 2) d = m_found;
        return {8'h00, d, m_found, 3'(m_misses), m_hit, m_miss,
                (m_phase == 1 || m_phase == 2), (m_phase == 3), (m_phase == 4)};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_show_left = 0; m_board = 8'h00; m_found = 8'h00;
        m_misses = 0; m_hit = 1'b0; m_miss = 1'b0;
    endtask

    task automatic model_edge(input logic bv, input logic [7:0] b, input logic gv, input int gi);
        m_hit = 1'b0;
        m_miss = 1'b0;
        if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
            if (bv) begin
                m_board = b; m_found = 8'h00; m_misses = 0;
                m_show_left = SHOW; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_show_left = m_show_left - 1;
            if (m_show_left == 0) m_phase = (m_board != 0) ? 2 : 3;
        end else if (gv) begin
            if (m_board[gi]) begin
                if (!m_found[gi]) begin
                    m_found[gi] = 1'b1;
                    m_hit = 1'b1;
                    if (m_found == m_board) m_phase = 3;
                end
            end else begin
                m_misses = m_misses + 1;
                m_miss = 1'b1;
                if (m_misses == MAXM) m_phase = 4;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare just after it.
    task automatic step(input string tag, input logic bv, input logic [7:0] b, input logic gv, input int gi);
        board_valid = bv;
        board = b;
        guess_valid = gv;
        guess_idx = 3'(gi);
        @(posedge clk);
        #1;
        model_edge(bv, b, gv, gi);
        check_vec(tag, observed(), expected());
        board_valid = 1'b0;
        guess_valid = 1'b0;
        board = 8'($urandom);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 8'($urandom), 1'b0, 0);
    endtask

    // Reset pulse placed between clock edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_vec(tag, observed(), expected());
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        board = 8'h00;
        board_valid = 1'b0;
        guess_valid = 1'b0;
        guess_idx = 3'd0;
        model_reset();
        #1;
        check_vec("reset", observed(), expected());
        #11;
        reset = 1'b0;

        // Show then recall, winning on guess 7.
        step("start85", 1'b1, 8'h85, 1'b0, 0);
        idle("show85", SHOW);
        step("g0", 1'b0, 8'h00, 1'b1, 0);
        idle("gap", 1);
        step("g2", 1'b0, 8'h00, 1'b1, 2);
        idle("gap", 1);
        step("g7win", 1'b0, 8'h00, 1'b1, 7);
        idle("won", 2);

        // Miss, hit, duplicate, miss, miss -> lose, then ignored guesses.
        step("start85b", 1'b1, 8'h85, 1'b0, 0);
        idle("show", SHOW);
        step("m1", 1'b0, 8'h00, 1'b1, 1);
        step("h0", 1'b0, 8'h00, 1'b1, 0);
        step("dup0", 1'b0, 8'h00, 1'b1, 0);
        step("m3", 1'b0, 8'h00, 1'b1, 3);
        step("m4lose", 1'b0, 8'h00, 1'b1, 4);
        step("lost_g", 1'b0, 8'h00, 1'b1, 5);
        step("lost_g", 1'b0, 8'h00, 1'b1, 7);

        // Restart out of LOSE.
        step("start3c", 1'b1, 8'h3C, 1'b0, 0);
        idle("show3c", SHOW);

        // Empty board wins straight from SHOW; inputs during SHOW are ignored.
        async_reset("rst_a");
        step("start00", 1'b1, 8'h00, 1'b0, 0);
        step("show_g", 1'b0, 8'hFF, 1'b1, 3);
        step("show_bv", 1'b1, 8'hFF, 1'b0, 0);
        idle("show00", SHOW - 2);
        idle("won00", 2);

        // Mid-recall reset after one hit and one miss.
        step("start85c", 1'b1, 8'h85, 1'b0, 0);
        idle("show", SHOW);
        step("h0", 1'b0, 8'h00, 1'b1, 0);
        step("m6", 1'b0, 8'h00, 1'b1, 6);
        async_reset("rst_mid");
        idle("after_rst", 1);
        step("restart", 1'b1, 8'h85, 1'b0, 0);
        idle("show", SHOW);
        step("h2", 1'b0, 8'h00, 1'b1, 2);

        // Randomized rounds, sparse boards make wins reachable.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] b;
            b = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'h00;
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 39) == 0), b,
                     ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
